// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache-side memory arbiter
//
// Purpose: common word and RAM-status types, plus the arbiter FSM state
// encoding and the width of the fairness streak counter.
// Ports: none (package).
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int STREAK_W  = 4;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// rtl/arb_streak_ctr.sv - saturating dcache grant streak counter for icache fairness
//
// Purpose: counts back-to-back dcache completions while the icache is waiting
// and asks the arbiter to force an icache grant once the limit is reached.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   dcomplete  a dcache access completed this cycle
//   icomplete  an icache access completed this cycle
//   iREN       icache request pending
//   force_i    icache must win the next arbitration
module arb_streak_ctr
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic dcomplete,
  input  logic icomplete,
  input  logic iREN,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DSTREAK_MAX);

  logic [STREAK_W-1:0] dstreak_q;
  logic [STREAK_W-1:0] dstreak_d;

  always_comb begin
    dstreak_d = dstreak_q;
    // Any cycle without a pending icache request resets the streak, so only
    // consecutive dcache wins that actually starve the icache are counted.
    if (!iREN || icomplete) begin
      dstreak_d = '0;
    end else if (dcomplete && (dstreak_q != STREAK_MAX)) begin
      dstreak_d = dstreak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dstreak_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

  assign force_i = iREN && (dstreak_q == STREAK_MAX);

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter driving a single shared RAM port
//
// Purpose: memory-side responder for the cache control interface. Grants the
// RAM to either cache, passes address/data through, and reports per-cache
// wait (low in the cycle the access completes).
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   iREN, iaddr / iwait, iload     icache read request and response
//   dREN, dWEN, daddr, dstore      dcache request
//   dwait, dload                   dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   shared RAM port
//   err_cnt                        saturating count of RAM ERROR cycles
module cache_mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int DSTREAK_MAX = 4,
  parameter int ERRCNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                iREN,
  input  logic [WORD_W-1:0]   iaddr,
  output logic                iwait,
  output logic [WORD_W-1:0]   iload,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [WORD_W-1:0]   daddr,
  input  logic [WORD_W-1:0]   dstore,
  output logic                dwait,
  output logic [WORD_W-1:0]   dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [WORD_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  input  logic [WORD_W-1:0]   ramload,
  input  logic [1:0]          ramstate,
  output logic [ERRCNT_W-1:0] err_cnt
);

  import cpu_types_pkg::*;

  arb_state_t          state_q;
  arb_state_t          state_d;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic [ERRCNT_W-1:0] err_cnt_d;

  ramstate_t rs;
  logic      dreq;
  logic      ram_ok;
  logic      dcomplete;
  logic      icomplete;
  logic      force_i;

  assign rs     = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign ram_ok = (rs == ACCESS);

  // Completion needs the owner still requesting: a withdrawn request that
  // coincides with ACCESS is not reported back to the cache.
  assign dcomplete = (state_q == DSERVE) && dreq && ram_ok;
  assign icomplete = (state_q == ISERVE) && iREN && ram_ok;

  arb_streak_ctr #(
    .DSTREAK_MAX(DSTREAK_MAX)
  ) u_streak (
    .CLK      (CLK),
    .RST      (RST),
    .dcomplete(dcomplete),
    .icomplete(icomplete),
    .iREN     (iREN),
    .force_i  (force_i)
  );

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE: begin
        if (dreq && !force_i) begin
          state_d = DSERVE;
        end else if (iREN) begin
          state_d = ISERVE;
        end
      end
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A write wins over a simultaneous read.
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        dload    = ramload;
        dwait    = !dcomplete;
        if (!dreq || ram_ok) begin
          state_d = IDLE;
        end
      end
      ISERVE: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !icomplete;
        if (!iREN || ram_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((rs == ERROR) && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
